// File: rtl/cnn_core_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cnn_core_scheduler                                               |
// | Brief   : Job FIFO, round-robin dispatch to CNN cores, result return.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module cnn_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int TAG_W     = 8,
  parameter int DATA_W    = 32,
  parameter int QDEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             job_valid,
  input  logic [TAG_W-1:0]                 job_tag,
  output logic                             job_ready,
  output logic [NUM_CORES-1:0]             core_enable,
  output logic [$clog2(NUM_CORES)-1:0]     disp_core,
  output logic [TAG_W-1:0]                 disp_tag,
  input  logic [NUM_CORES-1:0]             core_done,
  input  logic [NUM_CORES*DATA_W-1:0]      core_value,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [TAG_W-1:0]                 res_tag,
  output logic [$clog2(NUM_CORES)-1:0]     res_core,
  output logic [DATA_W-1:0]                res_value,
  output logic                             busy,
  output logic                             err_spurious
);

  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int QPTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W  = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    CORE_IDLE = 2'd0,
    CORE_RUN  = 2'd1,
    CORE_HOLD = 2'd2
  } core_state_e;

  logic [TAG_W-1:0]   qmem_q [QDEPTH];
  logic [TAG_W-1:0]   qmem_d [QDEPTH];
  logic [QPTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [QPTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               job_ready_q, job_ready_d;

  core_state_e        core_state_q [NUM_CORES];
  core_state_e        core_state_d [NUM_CORES];
  logic [TAG_W-1:0]   core_tag_q   [NUM_CORES];
  logic [TAG_W-1:0]   core_tag_d   [NUM_CORES];
  logic [DATA_W-1:0]  core_val_q   [NUM_CORES];
  logic [DATA_W-1:0]  core_val_d   [NUM_CORES];

  logic [CORE_W-1:0]  disp_rr_q, disp_rr_d;
  logic [CORE_W-1:0]  res_rr_q, res_rr_d;
  logic               res_valid_q, res_valid_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic [CORE_W-1:0]  res_core_q, res_core_d;
  logic [DATA_W-1:0]  res_value_q, res_value_d;
  logic               busy_q, busy_d;
  logic               err_spurious_q, err_spurious_d;

  logic [NUM_CORES-1:0] idle_mask, hold_mask;
  logic [CORE_W:0]      disp_pick, res_pick;
  logic                 do_disp, do_push, do_load, any_active;

  // Returns {found, index} of the first set mask bit at or after start, with wrap.
  function automatic logic [CORE_W:0] rr_pick(input logic [NUM_CORES-1:0] mask,
                                              input logic [CORE_W-1:0]    start);
    logic [CORE_W:0] r;
    int              idx;
    r = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (mask[idx]) r = {1'b1, CORE_W'(idx)};
    end
    return r;
  endfunction

  function automatic logic [CORE_W-1:0] rr_next(input logic [CORE_W-1:0] c);
    if (int'(c) == NUM_CORES - 1) return '0;
    return c + CORE_W'(1);
  endfunction

  always_comb begin
    qmem_d         = qmem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    core_state_d   = core_state_q;
    core_tag_d     = core_tag_q;
    core_val_d     = core_val_q;
    disp_rr_d      = disp_rr_q;
    res_rr_d       = res_rr_q;
    res_valid_d    = res_valid_q;
    res_tag_d      = res_tag_q;
    res_core_d     = res_core_q;
    res_value_d    = res_value_q;
    err_spurious_d = err_spurious_q;
    core_enable    = '0;
    disp_core      = '0;
    disp_tag       = '0;
    any_active     = 1'b0;

    for (int c = 0; c < NUM_CORES; c++) begin
      idle_mask[c] = (core_state_q[c] == CORE_IDLE);
      hold_mask[c] = (core_state_q[c] == CORE_HOLD);
    end

    // Dispatch is gated by rst so no start pulse escapes during a reset cycle.
    disp_pick = rr_pick(idle_mask, disp_rr_q);
    do_disp   = rst && (count_q != '0) && disp_pick[CORE_W];
    do_push   = job_valid && job_ready_q;

    if (do_push) begin
      qmem_d[wr_ptr_q] = job_tag;
      wr_ptr_d         = wr_ptr_q + QPTR_W'(1);
    end

    if (do_disp) begin
      core_enable[disp_pick[CORE_W-1:0]]  = 1'b1;
      disp_core                           = disp_pick[CORE_W-1:0];
      disp_tag                            = qmem_q[rd_ptr_q];
      rd_ptr_d                            = rd_ptr_q + QPTR_W'(1);
      core_state_d[disp_pick[CORE_W-1:0]] = CORE_RUN;
      core_tag_d[disp_pick[CORE_W-1:0]]   = qmem_q[rd_ptr_q];
      disp_rr_d                           = rr_next(disp_pick[CORE_W-1:0]);
    end

    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_disp);

    for (int c = 0; c < NUM_CORES; c++) begin
      if (core_done[c]) begin
        if (core_state_q[c] == CORE_RUN) begin
          core_state_d[c] = CORE_HOLD;
          core_val_d[c]   = core_value[c*DATA_W +: DATA_W];
        end else begin
          err_spurious_d = 1'b1;
        end
      end
    end

    res_pick = rr_pick(hold_mask, res_rr_q);
    do_load  = !res_valid_q || res_ready;
    if (do_load) begin
      res_valid_d = res_pick[CORE_W];
      if (res_pick[CORE_W]) begin
        res_tag_d                          = core_tag_q[res_pick[CORE_W-1:0]];
        res_core_d                         = res_pick[CORE_W-1:0];
        res_value_d                        = core_val_q[res_pick[CORE_W-1:0]];
        core_state_d[res_pick[CORE_W-1:0]] = CORE_IDLE;
        res_rr_d                           = rr_next(res_pick[CORE_W-1:0]);
      end
    end

    job_ready_d = (count_d != CNT_W'(QDEPTH));
    for (int c = 0; c < NUM_CORES; c++) begin
      if (core_state_d[c] != CORE_IDLE) any_active = 1'b1;
    end
    busy_d = (count_d != '0) || any_active || res_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) qmem_q[i] <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        core_state_q[c] <= CORE_IDLE;
        core_tag_q[c]   <= '0;
        core_val_q[c]   <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      job_ready_q    <= 1'b0;
      disp_rr_q      <= '0;
      res_rr_q       <= '0;
      res_valid_q    <= 1'b0;
      res_tag_q      <= '0;
      res_core_q     <= '0;
      res_value_q    <= '0;
      busy_q         <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      qmem_q         <= qmem_d;
      core_state_q   <= core_state_d;
      core_tag_q     <= core_tag_d;
      core_val_q     <= core_val_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      job_ready_q    <= job_ready_d;
      disp_rr_q      <= disp_rr_d;
      res_rr_q       <= res_rr_d;
      res_valid_q    <= res_valid_d;
      res_tag_q      <= res_tag_d;
      res_core_q     <= res_core_d;
      res_value_q    <= res_value_d;
      busy_q         <= busy_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign job_ready    = job_ready_q;
  assign res_valid    = res_valid_q;
  assign res_tag      = res_tag_q;
  assign res_core     = res_core_q;
  assign res_value    = res_value_q;
  assign busy         = busy_q;
  assign err_spurious = err_spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_core_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_cnn_core_scheduler                                            |
// | Brief   : Directed stimulus, queue-based reference model, per-cycle check. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_cnn_core_scheduler;

  localparam int NC = 4;
  localparam int TW = 8;
  localparam int DW = 32;
  localparam int QD = 4;

  logic            clk;
  logic            rst;
  logic            job_valid;
  logic [TW-1:0]   job_tag;
  logic            job_ready;
  logic [NC-1:0]   core_enable;
  logic [1:0]      disp_core;
  logic [TW-1:0]   disp_tag;
  logic [NC-1:0]   core_done;
  logic [NC*DW-1:0] core_value;
  logic            res_valid;
  logic            res_ready;
  logic [TW-1:0]   res_tag;
  logic [1:0]      res_core;
  logic [DW-1:0]   res_value;
  logic            busy;
  logic            err_spurious;

  int n_checks = 0;
  int n_fail   = 0;

  cnn_core_scheduler #(.NUM_CORES(NC), .TAG_W(TW), .DATA_W(DW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_tag(job_tag),
    .job_ready(job_ready), .core_enable(core_enable), .disp_core(disp_core),
    .disp_tag(disp_tag), .core_done(core_done), .core_value(core_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_core(res_core), .res_value(res_value), .busy(busy),
    .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Core status: 0 idle, 1 running, 2 result waiting.
  int          mq[$];
  int          mstate[NC];
  int          mtag[NC];
  logic [31:0] mval[NC];
  int          mdrr, mrrr;
  bit          mres_v;
  int          mres_tag, mres_core;
  logic [31:0] mres_val;
  bit          mready, merr, armed;

  function automatic int find_from(input int st[NC], input int want, input int start);
    for (int k = 0; k < NC; k++) begin
      if (st[(start + k) % NC] == want) return (start + k) % NC;
    end
    return -1;
  endfunction

  initial armed = 1'b0;

  always @(negedge clk) begin : p_model
    int  dc, hc;
    int  cur[NC];
    bit  eb;
    cur = mstate;
    if (armed) begin
      dc = (rst && mq.size() > 0) ? find_from(cur, 0, mdrr) : -1;
      check("core_enable", 64'(core_enable), (dc >= 0) ? 64'(1) << dc : 64'd0);
      if (dc >= 0) begin
        check("disp_core", 64'(disp_core), 64'(dc));
        check("disp_tag", 64'(disp_tag), 64'(mq[0]));
      end
      check("job_ready", 64'(job_ready), 64'(mready));
      check("res_valid", 64'(res_valid), 64'(mres_v));
      if (mres_v) begin
        check("res_tag", 64'(res_tag), 64'(mres_tag));
        check("res_core", 64'(res_core), 64'(mres_core));
        check("res_value", 64'(res_value), 64'(mres_val));
      end
      eb = (mq.size() != 0) || mres_v;
      for (int c = 0; c < NC; c++) if (mstate[c] != 0) eb = 1'b1;
      check("busy", 64'(busy), 64'(eb));
      check("err_spurious", 64'(err_spurious), 64'(merr));
    end
    if (!rst) begin
      mq.delete();
      for (int c = 0; c < NC; c++) begin mstate[c] = 0; mtag[c] = 0; mval[c] = 0; end
      mdrr = 0; mrrr = 0; mres_v = 0; mres_tag = 0; mres_core = 0; mres_val = 0;
      mready = 0; merr = 0; armed = 1'b1;
    end else begin
      dc = (mq.size() > 0) ? find_from(cur, 0, mdrr) : -1;
      if (dc >= 0) begin
        mtag[dc] = mq.pop_front();
        mstate[dc] = 1;
        mdrr = (dc + 1) % NC;
      end
      if (job_valid && mready) mq.push_back(int'(job_tag));
      for (int c = 0; c < NC; c++) begin
        if (core_done[c]) begin
          if (cur[c] == 1) begin
            mstate[c] = 2;
            mval[c] = core_value[c*DW +: DW];
          end else merr = 1'b1;
        end
      end
      if (!mres_v || res_ready) begin
        hc = find_from(cur, 2, mrrr);
        if (hc >= 0) begin
          mres_v = 1; mres_tag = mtag[hc]; mres_core = hc; mres_val = mval[hc];
          mstate[hc] = 0; mrrr = (hc + 1) % NC;
        end else mres_v = 0;
      end
      mready = (mq.size() != QD);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; job_valid = 1'b0; core_done = '0; res_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin : p_stim
    logic [3:0] rr_exp [6];
    rr_exp[0] = 4'b0000; rr_exp[1] = 4'b0001; rr_exp[2] = 4'b0010;
    rr_exp[3] = 4'b0100; rr_exp[4] = 4'b1000; rr_exp[5] = 4'b0000;

    rst = 1'b0; job_valid = 1'b1; job_tag = 8'h77; core_done = '0;
    core_value = '0; res_ready = 1'b1;

    // Reset held with a job offered
    cyc(); cyc(); cyc();
    check("rst_job_ready", 64'(job_ready), 64'd0);
    check("rst_enable", 64'(core_enable), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    rst = 1'b1; job_valid = 1'b0;
    cyc();
    check("rel_job_ready", 64'(job_ready), 64'd1);
    check("rel_busy", 64'(busy), 64'd0);

    // Single job
    job_valid = 1'b1; job_tag = 8'h11;
    cyc();
    check("single_enable", 64'(core_enable), 64'h1);
    check("single_disp_tag", 64'(disp_tag), 64'h11);
    job_valid = 1'b0;
    cyc();
    core_done = 4'b0001; core_value[0 +: DW] = 32'h0000_00A5;
    cyc();
    core_done = '0;
    cyc();
    check("single_res_valid", 64'(res_valid), 64'd1);
    check("single_res_tag", 64'(res_tag), 64'h11);
    check("single_res_core", 64'(res_core), 64'd0);
    check("single_res_value", 64'(res_value), 64'hA5);
    cyc();
    check("single_busy_clear", 64'(busy), 64'd0);

    // Round-robin fill
    do_reset();
    for (int k = 0; k < 6; k++) begin
      check("rr_enable", 64'(core_enable), 64'(rr_exp[k]));
      check("rr_job_ready", 64'(job_ready), 64'd1);
      job_valid = 1'b1; job_tag = 8'(k + 1);
      cyc();
    end
    job_valid = 1'b0;
    core_done = 4'b0100; core_value[2*DW +: DW] = 32'h0000_0033;
    cyc();
    core_done = '0;
    check("rr_wait_enable", 64'(core_enable), 64'd0);
    cyc();
    check("rr_res_tag", 64'(res_tag), 64'd3);
    check("rr_redisp_enable", 64'(core_enable), 64'b0100);
    check("rr_redisp_tag", 64'(disp_tag), 64'd5);
    cyc();

    // Queue full
    do_reset();
    for (int k = 0; k < 8; k++) begin
      check("full_ready_pre", 64'(job_ready), 64'd1);
      job_valid = 1'b1; job_tag = 8'(8'h20 + k);
      cyc();
    end
    check("full_ready_low", 64'(job_ready), 64'd0);
    job_tag = 8'h99;
    core_done = 4'b0010; core_value[1*DW +: DW] = 32'h0000_0055;
    cyc();
    core_done = '0;
    check("full_ready_still_low", 64'(job_ready), 64'd0);
    cyc();
    check("full_res_tag", 64'(res_tag), 64'h21);
    check("full_disp_enable", 64'(core_enable), 64'b0010);
    check("full_disp_tag", 64'(disp_tag), 64'h24);
    check("full_ready_at_pop", 64'(job_ready), 64'd0);
    job_valid = 1'b0;
    cyc();
    check("full_ready_back", 64'(job_ready), 64'd1);

    // Backpressure with simultaneous done
    do_reset();
    for (int k = 0; k < 4; k++) begin
      job_valid = 1'b1; job_tag = 8'(8'h40 + k);
      cyc();
    end
    job_valid = 1'b0;
    cyc();
    res_ready = 1'b0;
    core_done = 4'b1010;
    core_value[1*DW +: DW] = 32'h0000_0111;
    core_value[3*DW +: DW] = 32'hFFFF_FF00;
    cyc();
    core_done = '0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      check("bp_hold_valid", 64'(res_valid), 64'd1);
      check("bp_hold_core", 64'(res_core), 64'd1);
      check("bp_hold_tag", 64'(res_tag), 64'h41);
      check("bp_hold_value", 64'(res_value), 64'h111);
      if (k < 3) cyc();
    end
    res_ready = 1'b1;
    cyc();
    check("bp_second_valid", 64'(res_valid), 64'd1);
    check("bp_second_core", 64'(res_core), 64'd3);
    check("bp_second_value", 64'(res_value), 64'hFFFF_FF00);
    cyc();
    check("bp_drained", 64'(res_valid), 64'd0);

    // Spurious done on an idle core
    do_reset();
    core_done = 4'b0100;
    cyc();
    core_done = '0;
    check("spur_set", 64'(err_spurious), 64'd1);
    check("spur_no_result", 64'(res_valid), 64'd0);
    cyc(); cyc();
    check("spur_sticky", 64'(err_spurious), 64'd1);
    do_reset();
    check("spur_cleared", 64'(err_spurious), 64'd0);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
